trace_pkt_serializer: RTL

// - Consumer end of the core's per-cycle instruction trace bundle (up to 3 retiring slots per cycle).
// - Buffers whole trace packets and replays them as one-instruction-per-beat records over a valid/ready stream.
// - Feeds a debug trace port or memory. The core is never stalled: when the buffer is full, packets are

---
 rtl/trace_pkt_serializer_if.sv | 25 ++
 rtl/trace_pkt_serializer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/trace_pkt_serializer_if.sv
// Trace record stream between the serializer (master) and a trace sink (slave).
// Carries one retired instruction per beat with valid/ready flow control.
// Ports: tr_valid/tr_ready handshake, tr_slot/insn/addr/exc/int/ecause/tval/ovf record payload.
interface trace_pkt_serializer_if;
  logic        tr_valid;
  logic        tr_ready;
  logic [1:0]  tr_slot;
  logic [31:0] tr_insn;
  logic [31:0] tr_addr;
  logic        tr_exc;
  logic        tr_int;
  logic [4:0]  tr_ecause;
  logic [31:0] tr_tval;
  logic        tr_ovf;

  modport master (
    output tr_valid, tr_slot, tr_insn, tr_addr, tr_exc, tr_int, tr_ecause, tr_tval, tr_ovf,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_slot, tr_insn, tr_addr, tr_exc, tr_int, tr_ecause, tr_tval, tr_ovf,
    output tr_ready
  );
endinterface

// File: rtl/trace_pkt_serializer.sv
// Buffers 3-slot retire-trace packets and replays them as one-instruction-per-beat records.
// Latency: first record valid the cycle after the push into an empty FIFO; 1 record/cycle sustained.
// Backpressure: records hold while tr_ready=0; core never stalls, packets arriving when full are dropped and counted.
// Ports: clk, rst_l (async low), trace_rv_i_* packet inputs, tr (record stream master), drop_cnt (saturating drops).
module trace_pkt_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [2:0]           trace_rv_i_valid_ip,
  input  logic [95:0]          trace_rv_i_insn_ip,
  input  logic [95:0]          trace_rv_i_address_ip,
  input  logic [2:0]           trace_rv_i_exception_ip,
  input  logic [4:0]           trace_rv_i_ecause_ip,
  input  logic [2:0]           trace_rv_i_interrupt_ip,
  input  logic [31:0]          trace_rv_i_tval_ip,
  trace_pkt_serializer_if.master tr,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  valid;
    logic [95:0] insn;
    logic [95:0] addr;
    logic [2:0]  exc;
    logic [2:0]  intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        ovf;
  } entry_t;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic        fifo_full;
  logic        ovf_pend;

  state_t      state_q, state_d;
  logic [2:0]  sent_q, sent_d;   // slots of the head entry already handed to the sink
  logic [2:0]  rem, slot_oh, rem_after;
  logic [1:0]  slot;
  logic        hs, pop, push_req, push_ok, drop, flagged;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    state_d   = state_q;
    sent_d    = sent_q;
    rem       = 3'b000;
    slot      = 2'd0;
    slot_oh   = 3'b000;
    rem_after = 3'b000;
    hs        = 1'b0;
    pop       = 1'b0;
    flagged   = 1'b0;

    if (state_q == S_EMIT) begin
      // Lowest valid slot not yet sent; an entry always has at least one left while it is at the head.
      rem = head.valid & ~sent_q;
      if (rem[0]) begin
        slot = 2'd0; slot_oh = 3'b001;
      end else if (rem[1]) begin
        slot = 2'd1; slot_oh = 3'b010;
      end else begin
        slot = 2'd2; slot_oh = 3'b100;
      end
      rem_after = rem & ~slot_oh;
      hs        = tr.tr_ready;
      pop       = hs && (rem_after == 3'b000);
      flagged   = head.exc[slot] | head.intr[slot];
    end

    // A pop in the same cycle frees the slot the incoming packet needs.
    push_req = |trace_rv_i_valid_ip;
    push_ok  = push_req && (!fifo_full || pop);
    drop     = push_req && fifo_full && !pop;

    wr_ptr_d = wr_ptr + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr + {{AW{1'b0}}, pop};

    if (hs) sent_d = pop ? 3'b000 : (sent_q | slot_oh);
    state_d = (wr_ptr_d != rd_ptr_d) ? S_EMIT : S_IDLE;

    tr.tr_valid  = (state_q == S_EMIT);
    tr.tr_slot   = tr.tr_valid ? slot : 2'd0;
    tr.tr_insn   = tr.tr_valid ? head.insn[{slot, 5'b0} +: 32] : 32'd0;
    tr.tr_addr   = tr.tr_valid ? head.addr[{slot, 5'b0} +: 32] : 32'd0;
    tr.tr_exc    = tr.tr_valid ? head.exc[slot] : 1'b0;
    tr.tr_int    = tr.tr_valid ? head.intr[slot] : 1'b0;
    tr.tr_ecause = flagged ? head.ecause : 5'd0;
    tr.tr_tval   = flagged ? head.tval : 32'd0;
    // Overflow marker rides only on the first record of the entry.
    tr.tr_ovf    = tr.tr_valid && head.ovf && (sent_q == 3'b000);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= S_IDLE;
      sent_q   <= 3'b000;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ovf_pend <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      if (drop) begin
        ovf_pend <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end else if (push_ok) begin
        ovf_pend <= 1'b0;
      end
    end
  end

  // Storage is not reset; outputs are gated by the FSM state so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= '{
        valid:  trace_rv_i_valid_ip,
        insn:   trace_rv_i_insn_ip,
        addr:   trace_rv_i_address_ip,
        exc:    trace_rv_i_exception_ip,
        intr:   trace_rv_i_interrupt_ip,
        ecause: trace_rv_i_ecause_ip,
        tval:   trace_rv_i_tval_ip,
        ovf:    ovf_pend
      };
    end
  end

endmodule
